// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, applies stall/flush, selects ALU operands
// and counts bubble cycles. Define ID_EX_FORWARDING_EN to add MEM/WB operand forwarding.
module id_ex_stage (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_imm,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic [4:0]  i_rd_addr,
    input  logic [3:0]  i_alucontrol,
    input  logic        i_alusrc_b,
    input  logic        i_asel_pc,
    input  logic        i_regwrite,
    input  logic        i_mem_regwrite,
    input  logic        i_wb_regwrite,
    input  logic [4:0]  i_mem_rd_addr,
    input  logic [4:0]  i_wb_rd_addr,
    input  logic [31:0] i_mem_result,
    input  logic [31:0] i_wb_result,
    output logic        o_valid,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_store_data,
    output logic [31:0] o_pc,
    output logic [3:0]  o_alucontrol,
    output logic [4:0]  o_rd_addr,
    output logic        o_regwrite,
    output logic [15:0] o_bubble_cnt
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] rs1_data_q;
    logic [31:0] rs2_data_q;
    logic [31:0] imm_q;
    logic [4:0]  rs1_addr_q;
    logic [4:0]  rs2_addr_q;
    logic [4:0]  rd_addr_q;
    logic [3:0]  alucontrol_q;
    logic        alusrc_b_q;
    logic        asel_pc_q;
    logic        regwrite_q;
    logic [15:0] bubble_cnt_q;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;

    // Flush outranks stall; a stalled stage simply keeps its contents.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_addr_q    <= '0;
            alucontrol_q <= '0;
            alusrc_b_q   <= 1'b0;
            asel_pc_q    <= 1'b0;
            regwrite_q   <= 1'b0;
        end else if (i_flush) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_addr_q    <= '0;
            alucontrol_q <= '0;
            alusrc_b_q   <= 1'b0;
            asel_pc_q    <= 1'b0;
            regwrite_q   <= 1'b0;
        end else if (!i_stall) begin
            valid_q      <= i_valid;
            pc_q         <= i_pc;
            rs1_data_q   <= i_rs1_data;
            rs2_data_q   <= i_rs2_data;
            imm_q        <= i_imm;
            rs1_addr_q   <= i_rs1_addr;
            rs2_addr_q   <= i_rs2_addr;
            rd_addr_q    <= i_rd_addr;
            alucontrol_q <= i_alucontrol;
            alusrc_b_q   <= i_alusrc_b;
            asel_pc_q    <= i_asel_pc;
            regwrite_q   <= i_regwrite & i_valid;
        end
    end

    // Bubble counter saturates rather than wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bubble_cnt_q <= '0;
        end else if (!valid_q && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (i_mem_regwrite && (i_mem_rd_addr == rs1_addr_q) && (rs1_addr_q != 5'd0)) begin
            fwd_rs1 = i_mem_result;
        end else if (i_wb_regwrite && (i_wb_rd_addr == rs1_addr_q) && (rs1_addr_q != 5'd0)) begin
            fwd_rs1 = i_wb_result;
        end
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (i_mem_regwrite && (i_mem_rd_addr == rs2_addr_q) && (rs2_addr_q != 5'd0)) begin
            fwd_rs2 = i_mem_result;
        end else if (i_wb_regwrite && (i_wb_rd_addr == rs2_addr_q) && (rs2_addr_q != 5'd0)) begin
            fwd_rs2 = i_wb_result;
        end
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{i_mem_regwrite, i_wb_regwrite, i_mem_rd_addr, i_wb_rd_addr,
                                 i_mem_result, i_wb_result, rs1_addr_q, rs2_addr_q};
    assign fwd_rs1 = rs1_data_q;
    assign fwd_rs2 = rs2_data_q;
`endif

    assign o_a          = asel_pc_q ? pc_q : fwd_rs1;
    assign o_b          = alusrc_b_q ? imm_q : fwd_rs2;
    assign o_store_data = fwd_rs2;
    assign o_valid      = valid_q;
    assign o_pc         = pc_q;
    assign o_alucontrol = alucontrol_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_regwrite   = regwrite_q;
    assign o_bubble_cnt = bubble_cnt_q;

endmodule
